cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Two-way set-associative, write-through, no-write-allocate cache controller between the EXE/MEM pipeline register and the external SRAM controller. It accepts the memory-stage request (address, store data, read/write enables) and serves read hits in zero extra cycles. On read misses and all writes it runs an SRAM handshake, holding `ready` low so the pipeline freezes (`freeze = ~ready`) until the access completes.

## Interface
Parameters:
- `INDEX_W`, 6, set index width (64 sets)
- `TAG_W`, 10, tag width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `addr`  in  32  byte address from the memory stage
- `wdata`  in  32  store data
- `mem_r_en`  in  1  load request
- `mem_w_en`  in  1  store request
- `rdata`  out  32  load data, valid when `ready`=1 and `mem_r_en`=1
- `ready`  out  1  request complete; pipeline freeze = `~ready`
- `sram_addr`  out  32  SRAM address
- `sram_wdata`  out  32  SRAM store data
- `sram_r_en`  out  1  SRAM 64-bit line read request
- `sram_w_en`  out  1  SRAM 32-bit word write request
- `sram_rdata`  in  64  SRAM line data
- `sram_ready`  in  1  SRAM access done (single-cycle pulse)

## Operation
- Address split:
  - `addr[1:0]` ignored.
  - `addr[2]` is the word select: 0 = `line[31:0]`, 1 = `line[63:32]`.
  - `addr[8:3]` is the index.
  - `addr[18:9]` is the tag.
- Storage per set:
  - Per way: valid bit, tag, 64-bit line.
  - Per set: one `lru` bit naming the victim way.
- Hit: the way is valid and its tag matches. Hits in both ways cannot occur.
- LRU update: any hit or fill to way w sets `lru[set] <= ~w`.
- Victim selection: way0 if invalid, else way1 if invalid, else `lru[set]`.
- FSM states IDLE, RD_MISS, WRITE:
  - IDLE, `mem_w_en`=1 → WRITE. `mem_w_en` has priority if both enables are high.
  - IDLE, `mem_r_en`=1 and miss → RD_MISS.
  - IDLE, `mem_r_en`=1 and hit → stay in IDLE; `rdata` = hit word, `ready`=1.
  - RD_MISS:
    - `sram_r_en`=1, `sram_addr` = {`addr[31:3]`, 3'b000}.
    - On `sram_ready`: write `sram_rdata` into the victim way, set its valid bit and tag, update `lru`, return IDLE.
  - WRITE:
    - `sram_w_en`=1, `sram_addr` = `addr`, `sram_wdata` = `wdata`.
    - On a write hit, the hit word in the cache is updated and `lru` is updated on the completing edge.
    - On a write miss, nothing is allocated.
    - On `sram_ready`: return IDLE.
- `ready`:
  - 1 when there is no request, or on a read hit in IDLE.
  - In RD_MISS and WRITE, `ready` = `sram_ready`.
  - It is 0 in the IDLE cycle that detects a miss or write.
- `rdata` during RD_MISS with `sram_ready`=1: the selected word of `sram_rdata`, bypassed combinationally.
- With no load in progress, `rdata` = 0.

## Timing
- Reset: the following take effect immediately, with no clock required:
  - state = IDLE
  - all valid bits = 0, all `lru` = 0
  - `sram_r_en` = `sram_w_en` = 0, `sram_addr` = `sram_wdata` = 0
  - `rdata` = 0, `ready` = 1
- Reset during RD_MISS or WRITE aborts the access. SRAM enables drop asynchronously, no fill occurs, and later `sram_ready` pulses in IDLE are ignored.
- Read hit: 0 stall cycles, data is combinational.
- Read miss: one IDLE detect cycle, then N RD_MISS cycles until `sram_ready`. The pipeline advances on the same edge that fills the cache.
- Write: one IDLE detect cycle, then WRITE until `sram_ready`.
- The requester holds `addr`, `wdata` and the enables stable while `ready`=0. The frozen pipeline register guarantees this.
- The SRAM request stays asserted continuously from the cycle after detection through the `sram_ready` cycle. The following cycle is IDLE with both SRAM enables low. Each access issues exactly one SRAM request.
- No SRAM enable is ever asserted in IDLE.

## Test plan
- Cold read miss: after reset, read `0x408`, SRAM returns `64'h1111_2222_3333_4444` after 3 cycles → `sram_r_en`=1 with `sram_addr`=`0x400`; `ready`=0 for 3 cycles; `rdata`=`0x33334444` with `ready`=1 in the `sram_ready` cycle.
- Same-line hit: then read `0x40C` → `ready`=1 in the same cycle, `rdata`=`0x11112222`, `sram_r_en` stays 0.
- LRU replacement, all in set 1:
  - Fill `0x408` (way0), then fill `0x608` (way1).
  - Read hit `0x408`.
  - Read `0x808` → misses and evicts way1 (`0x608`).
  - Read `0x408` → hit. Read `0x608` → miss.
- Write hit: after filling `0x408`, write `0xDEADBEEF` to `0x40C` → `sram_w_en`=1, `sram_addr`=`0x40C`, `sram_wdata`=`0xDEADBEEF`, `ready` low until `sram_ready`. A following read of `0x40C` hits and returns `0xDEADBEEF`.
- Write miss: write `0x1000` → SRAM write completes. A following read of `0x1000` misses (`sram_r_en`=1), confirming no allocation.
- Reset mid-miss: assert `rst` during RD_MISS → `sram_r_en` drops immediately and `ready`=1. A later `sram_ready` pulse changes nothing, and re-reading the address misses again.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: two-way set-associative write-through, no-write-allocate cache in front of the SRAM controller.
module cache_ctrl #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    localparam int SETS = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WRITE} state_t;

    state_t state, state_nx;

    logic [SETS-1:0]  valid [2];
    logic [SETS-1:0]  lru;
    logic [TAG_W-1:0] tags  [2][SETS];
    logic [63:0]      lines [2][SETS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tg;
    logic               hit0, hit1, hit, hit_way, victim, rd_hit, fill, wr_hit_done;
    logic [63:0]        hit_line;
    logic [31:0]        hit_word, sram_word;

    assign idx         = addr[3 +: INDEX_W];
    assign tg          = addr[3 + INDEX_W +: TAG_W];
    assign hit0        = valid[0][idx] && tags[0][idx] == tg;
    assign hit1        = valid[1][idx] && tags[1][idx] == tg;
    assign hit         = hit0 || hit1;
    assign hit_way     = hit1;
    assign hit_line    = hit1 ? lines[1][idx] : lines[0][idx];
    assign hit_word    = addr[2] ? hit_line[63:32] : hit_line[31:0];
    assign sram_word   = addr[2] ? sram_rdata[63:32] : sram_rdata[31:0];
    assign victim      = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
    assign rd_hit      = state == IDLE && mem_r_en && !mem_w_en && hit;
    assign fill        = state == RD_MISS && sram_ready;
    assign wr_hit_done = state == WRITE && sram_ready && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (mem_w_en ? WRITE : (mem_r_en && !hit) ? RD_MISS : IDLE)
                                 : (sram_ready ? IDLE : state);
    end

    always_comb begin
        sram_r_en  = state == RD_MISS;
        sram_w_en  = state == WRITE;
        sram_addr  = sram_r_en ? {addr[31:3], 3'b000} : sram_w_en ? addr : 32'd0;
        sram_wdata = sram_w_en ? wdata : 32'd0;
        ready      = rst || (state == IDLE ? !(mem_w_en || (mem_r_en && !hit)) : sram_ready);
        rdata      = rst ? 32'd0 : rd_hit ? hit_word : fill ? sram_word : 32'd0;
    end

    // Only the control bits need clearing; line and tag contents are meaningless while invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
        end else if (fill) begin
            valid[victim][idx] <= 1'b1;
            lru[idx]           <= ~victim;
        end else if (rd_hit || wr_hit_done) begin
            lru[idx] <= ~hit_way;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tags[victim][idx]  <= tg;
            lines[victim][idx] <= sram_rdata;
        end else if (wr_hit_done) begin
            if (addr[2]) lines[hit_way][idx][63:32] <= wdata;
            else lines[hit_way][idx][31:0] <= wdata;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed plus random accesses checked against a recency-list cache model and a flat memory model.
module tb_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata, sram_addr, sram_wdata;
    logic        mem_r_en, mem_w_en, ready, sram_r_en, sram_w_en, sram_ready;
    logic [63:0] sram_rdata;

    int tests = 0;
    int fails = 0;

    logic [63:0] mem [logic [28:0]];
    logic [28:0] res [64][$];

    cache_ctrl dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_r_en(sram_r_en),
        .sram_w_en(sram_w_en), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [28:0] k;
        k = a[31:3];
        if (mem.exists(k)) return mem[k];
        return {32'(k) * 32'h9E37_79B1, 32'(k) ^ 32'hC0DE_0000};
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 64; s++) res[s].delete();
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, " ready"}, ready, 1);
        check({tag, " rdata"}, rdata, 0);
        check({tag, " sram_r_en"}, sram_r_en, 0);
        check({tag, " sram_w_en"}, sram_w_en, 0);
    endtask

    // One pipeline access starting and ending at a falling edge; lat = SRAM wait cycles before sram_ready.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input int lat);
        int          s;
        int          pos;
        logic [28:0] key;
        logic [63:0] line;
        logic [31:0] word;
        s    = int'(a[8:3]);
        key  = a[31:3];
        pos  = -1;
        foreach (res[s][i]) if (res[s][i] == key) pos = i;
        line = line_of(a);
        word = a[2] ? line[63:32] : line[31:0];
        addr = a; wdata = d; mem_r_en = !wr; mem_w_en = wr;
        #1;
        if (!wr && pos >= 0) begin
            check("hit ready", ready, 1);
            check("hit rdata", rdata, word);
            check("hit sram_r_en", sram_r_en, 0);
            res[s].delete(pos);
            res[s].push_back(key);
            @(negedge clk);
        end else begin
            check("detect ready", ready, 0);
            check("detect sram_en", {sram_r_en, sram_w_en}, 0);
            @(negedge clk);
            for (int k = 0; k <= lat; k++) begin
                if (k == lat) begin
                    sram_ready = 1'b1;
                    sram_rdata = wr ? {$urandom, $urandom} : line;
                end
                #1;
                check(wr ? "sram_w_en" : "sram_r_en", wr ? sram_w_en : sram_r_en, 1);
                check("other sram_en", wr ? sram_r_en : sram_w_en, 0);
                check("sram_addr", sram_addr, wr ? a : {a[31:3], 3'b000});
                if (wr) check("sram_wdata", sram_wdata, d);
                check("busy ready", ready, k == lat);
                if (!wr && k == lat) check("miss rdata", rdata, word);
                @(negedge clk);
                sram_ready = 1'b0;
            end
            if (wr) begin
                if (a[2]) line[63:32] = d;
                else line[31:0] = d;
                mem[key] = line;
                if (pos >= 0) begin
                    res[s].delete(pos);
                    res[s].push_back(key);
                end
            end else begin
                if (res[s].size() == 2) void'(res[s].pop_front());
                res[s].push_back(key);
            end
        end
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        check_idle("after access");
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = 32'h408; wdata = 0; mem_r_en = 1'b1; mem_w_en = 1'b0;
        sram_ready = 1'b0; sram_rdata = 0;
        #1;
        check("reset ready", ready, 1);
        check("reset rdata", rdata, 0);
        check("reset sram_addr", sram_addr, 0);
        check("reset sram_wdata", sram_wdata, 0);
        check("reset sram_en", {sram_r_en, sram_w_en}, 0);
        mem_r_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
        check_idle("post reset");
        @(negedge clk);

        mem[29'(32'h408 >> 3)] = 64'h1111_2222_3333_4444;
        access(0, 32'h408, 0, 3);
        access(0, 32'h40C, 0, 0);
        access(0, 32'h608, 0, 1);
        access(0, 32'h408, 0, 0);
        access(0, 32'h808, 0, 2);
        access(0, 32'h408, 0, 0);
        access(0, 32'h608, 0, 1);
        access(1, 32'h40C, 32'hDEAD_BEEF, 2);
        access(0, 32'h40C, 0, 0);
        access(1, 32'h1000, 32'h1234_5678, 1);
        access(0, 32'h1000, 0, 2);

        // Reset in the middle of a line fill must abort it cleanly.
        addr = 32'h2008; mem_r_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre-abort sram_r_en", sram_r_en, 1);
        rst = 1'b1;
        #1;
        check("abort sram_r_en", sram_r_en, 0);
        check("abort ready", ready, 1);
        check("abort sram_addr", sram_addr, 0);
        @(negedge clk);
        rst = 1'b0; mem_r_en = 1'b0;
        clear_model();
        sram_ready = 1'b1; sram_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
        check_idle("stray sram_ready");
        @(negedge clk);
        sram_ready = 1'b0;
        check_idle("after stray");
        @(negedge clk);
        access(0, 32'h2008, 0, 1);
        access(0, 32'h408, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {13'd0, 10'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 1'($urandom), 2'b00};
            access($urandom_range(0, 9) < 3, a, $urandom, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
